seq_pattern_detector: RTL and testbench

//   Parametrised serial pattern detector: samples one bit of A per enabled CLK edge and

---
 rtl/seq_pattern_detector.sv | 95 +++++++++
 tb/tb_seq_pattern_detector.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: shifts one bit of A per enabled edge, pulses Y when the
// last N samples equal the loadable pattern, and keeps a saturating match count.
module seq_pattern_detector #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b101,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             A,
  input  logic             LOAD,
  input  logic [N-1:0]     PAT_IN,
  input  logic             CLR_CNT,
  output logic             Y,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic             SAT
);

  localparam int                FILL_W    = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

  logic [N-1:0]      pat_q,  pat_d;
  logic [N-1:0]      hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              y_q,    y_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              sat_q,  sat_d;

  logic [N-1:0]      hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              match;

  always_comb begin
    pat_d    = pat_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    y_d      = 1'b0;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    match    = 1'b0;
    hist_nxt = {hist_q[N-2:0], A};
    fill_nxt = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    cnt_inc  = cnt_q + CNT_W'(1);

    // A load restarts the history and swallows the bit presented on the same edge
    if (LOAD) begin
      pat_d  = PAT_IN;
      hist_d = '0;
      fill_d = '0;
    end else if (EN) begin
      hist_d = hist_nxt;
      fill_d = fill_nxt;
      match  = (fill_nxt == FILL_FULL) && (hist_nxt == pat_q);
      if (match) begin
        y_d = 1'b1;
        if (!OVERLAP) fill_d = '0;
      end
    end

    // Clear wins over a coincident match; the count never wraps
    if (CLR_CNT) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match && !(&cnt_q)) begin
      cnt_d = cnt_inc;
      sat_d = sat_q | (&cnt_inc);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign Y         = y_q;
  assign MATCH_CNT = cnt_q;
  assign SAT       = sat_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench: one default detector, one non-overlapping, one with a 2-bit counter,
// all sharing stimulus; expected values are worked out by hand per edge.
module tb_seq_pattern_detector;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN = 1'b0;
  logic       A = 1'b0;
  logic       LOAD = 1'b0;
  logic [2:0] PAT_IN = 3'b000;
  logic       CLR_CNT = 1'b0;

  logic       y_ov, y_nov, y_c2;
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_c2;
  logic       sat_ov, sat_nov, sat_c2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  seq_pattern_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) u_dut_ov (
    .CLK(CLK), .RESET(RESET), .EN(EN), .A(A), .LOAD(LOAD), .PAT_IN(PAT_IN),
    .CLR_CNT(CLR_CNT), .Y(y_ov), .MATCH_CNT(cnt_ov), .SAT(sat_ov));

  seq_pattern_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u_dut_nov (
    .CLK(CLK), .RESET(RESET), .EN(EN), .A(A), .LOAD(LOAD), .PAT_IN(PAT_IN),
    .CLR_CNT(CLR_CNT), .Y(y_nov), .MATCH_CNT(cnt_nov), .SAT(sat_nov));

  seq_pattern_detector #(.N(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) u_dut_c2 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .A(A), .LOAD(LOAD), .PAT_IN(PAT_IN),
    .CLR_CNT(CLR_CNT), .Y(y_c2), .MATCH_CNT(cnt_c2), .SAT(sat_c2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given EN/A; outputs are sampled 1ns after the edge
  task automatic tick(input logic en, input logic a);
    EN = en;
    A  = a;
    @(posedge CLK);
    #1;
    EN      = 1'b0;
    LOAD    = 1'b0;
    CLR_CNT = 1'b0;
    RESET   = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick(1'b0, 1'b0);
    RESET = 1'b1;
    tick(1'b0, 1'b0);
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_y", y_ov, 0);
    chk("rst_cnt", cnt_ov, 0);
    chk("rst_sat", sat_ov, 0);

    // 1: basic 101
    tick(1, 1); chk("t1_e1_y", y_ov, 0);
    tick(1, 0); chk("t1_e2_y", y_ov, 0);
    tick(1, 1); chk("t1_e3_y", y_ov, 1); chk("t1_cnt", cnt_ov, 1);
    tick(0, 1); chk("t1_idle_y", y_ov, 0);

    // 2: 10101 overlapping vs non-overlapping
    do_reset();
    tick(1, 1); chk("t2_e1_ov", y_ov, 0); chk("t2_e1_nov", y_nov, 0);
    tick(1, 0); chk("t2_e2_ov", y_ov, 0); chk("t2_e2_nov", y_nov, 0);
    tick(1, 1); chk("t2_e3_ov", y_ov, 1); chk("t2_e3_nov", y_nov, 1);
    tick(1, 0); chk("t2_e4_ov", y_ov, 0); chk("t2_e4_nov", y_nov, 0);
    tick(1, 1); chk("t2_e5_ov", y_ov, 1); chk("t2_e5_nov", y_nov, 0);
    chk("t2_cnt_ov", cnt_ov, 2);
    chk("t2_cnt_nov", cnt_nov, 1);

    // 3: EN gaps hold history
    do_reset();
    tick(1, 1);
    tick(1, 0); chk("t3_e2_y", y_ov, 0);
    tick(0, 1); chk("t3_gap1_y", y_ov, 0);
    tick(0, 1); chk("t3_gap2_y", y_ov, 0);
    tick(1, 1); chk("t3_final_y", y_ov, 1);

    // 4: load 110, same-edge A discarded
    do_reset();
    LOAD = 1'b1; PAT_IN = 3'b110;
    tick(1, 1); chk("t4_load_y", y_ov, 0);
    tick(1, 1); chk("t4_a1_y", y_ov, 0);
    tick(1, 0); chk("t4_discard_y", y_ov, 0);
    tick(1, 1); chk("t4_b1_y", y_ov, 0);
    tick(1, 1); chk("t4_b2_y", y_ov, 0);
    tick(1, 0); chk("t4_b3_y", y_ov, 1);
    tick(1, 1); chk("t4_c1_y", y_ov, 0);
    tick(1, 0); chk("t4_c2_y", y_ov, 0);
    tick(1, 1); chk("t4_c3_y", y_ov, 0);
    chk("t4_cnt", cnt_ov, 1);

    // 5: 2-bit counter saturation and clear-wins
    do_reset();
    tick(1, 1); tick(1, 0); tick(1, 1);
    chk("t5_m1_cnt", cnt_c2, 1);
    tick(1, 0); tick(1, 1);
    chk("t5_m2_cnt", cnt_c2, 2); chk("t5_m2_sat", sat_c2, 0);
    tick(1, 0); tick(1, 1);
    chk("t5_m3_cnt", cnt_c2, 3); chk("t5_m3_sat", sat_c2, 1);
    tick(1, 0); tick(1, 1);
    chk("t5_m4_y", y_c2, 1);
    chk("t5_m4_cnt", cnt_c2, 3); chk("t5_m4_sat", sat_c2, 1);
    tick(1, 0);
    CLR_CNT = 1'b1;
    tick(1, 1);
    chk("t5_clr_y", y_c2, 1); chk("t5_clr_cnt", cnt_c2, 0); chk("t5_clr_sat", sat_c2, 0);
    tick(1, 0); tick(1, 1);
    chk("t5_after_clr_cnt", cnt_c2, 1);

    // 6: reset beats a completing match, restores PATTERN and restarts fill
    do_reset();
    LOAD = 1'b1; PAT_IN = 3'b110;
    tick(0, 0);
    tick(1, 1); tick(1, 1);
    RESET = 1'b1;
    tick(1, 0);
    chk("t6_rst_y", y_ov, 0); chk("t6_rst_cnt", cnt_ov, 0);
    tick(1, 1); chk("t6_r1_y", y_ov, 0);
    tick(1, 0); chk("t6_r2_y", y_ov, 0);
    tick(1, 1); chk("t6_pat_restored_y", y_ov, 1);
    chk("t6_cnt", cnt_ov, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
